// File: rtl/clocks_pkg.sv
// Shared types and constants for the clock/reset sequencing slice.
package clocks_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PPU_HOLD  = 2'd1,
    CPU_HOLD  = 2'd2,
    RUN       = 2'd3
  } reset_state_t;

  localparam int unsigned NES_CPU_DIV  = 3;
  localparam logic [7:0]  LOSS_CNT_MAX = 8'hFF;

  // Divide-by-NES_CPU_DIV phase counter step: 0,1,2,0,...
  function automatic logic [1:0] div_next(input logic [1:0] div);
    return (div == 2'(NES_CPU_DIV - 1)) ? 2'd0 : div + 2'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Sequences PPU then CPU reset release from MMCM lock and a debounced button,
// and generates the divide-by-3 CPU / M2 clock enables.
module reset_seq
  import clocks_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned PPU_HOLD_CYCLES = 64,
  parameter int unsigned CPU_HOLD_CYCLES = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_ppu,
  input  logic       rst_clocks_n,
  input  logic       locked,
  input  logic       btn_reset,
  output logic       rst_ppu,
  output logic       rst_cpu,
  output logic       cpu_en,
  output logic       cpum2_en,
  output logic [1:0] seq_state,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned HOLD_W = $clog2(PPU_HOLD_CYCLES + 1);
  localparam int unsigned CPU_W  = $clog2(CPU_HOLD_CYCLES + 1);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  logic locked_s;
  logic btn_s;
  logic abort;

  reset_state_t state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CPU_W-1:0]  cpu_hold_q, cpu_hold_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              btn_db_q, btn_db_d;
  logic [1:0]        div_q, div_d;
  logic              rst_ppu_q, rst_ppu_d;
  logic              rst_cpu_q, rst_cpu_d;
  logic              cpu_en_q, cpu_en_d;
  logic              cpum2_en_q, cpum2_en_d;
  logic [7:0]        loss_q, loss_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk   (clk_ppu),
    .rst_n (rst_clocks_n),
    .d     (locked),
    .q     (locked_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk   (clk_ppu),
    .rst_n (rst_clocks_n),
    .d     (btn_reset),
    .q     (btn_s)
  );

  // Any sample equal to the current debounced level restarts the count.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign abort = !locked_s || btn_db_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cpu_hold_d = cpu_hold_q;
    div_d      = div_q;
    rst_ppu_d  = rst_ppu_q;
    rst_cpu_d  = rst_cpu_q;

    case (state_q)
      WAIT_LOCK: begin
        rst_ppu_d = 1'b1;
        rst_cpu_d = 1'b1;
        div_d     = 2'd0;
        if (!abort) begin
          state_d = PPU_HOLD;
          hold_d  = HOLD_W'(PPU_HOLD_CYCLES - 1);
        end
      end
      PPU_HOLD: begin
        if (hold_q == '0) begin
          state_d    = CPU_HOLD;
          rst_ppu_d  = 1'b0;
          div_d      = 2'd0;
          cpu_hold_d = CPU_W'(CPU_HOLD_CYCLES - 1);
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      CPU_HOLD: begin
        div_d = div_next(div_q);
        // div_q==2 is the cycle cpu_en is high; decide at its closing edge.
        if (div_q == 2'(NES_CPU_DIV - 1)) begin
          if (cpu_hold_q == '0) begin
            state_d   = RUN;
            rst_cpu_d = 1'b0;
          end else begin
            cpu_hold_d = cpu_hold_q - 1'b1;
          end
        end
      end
      RUN: begin
        div_d = div_next(div_q);
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    if (abort && state_q != WAIT_LOCK) begin
      state_d   = WAIT_LOCK;
      rst_ppu_d = 1'b1;
      rst_cpu_d = 1'b1;
      div_d     = 2'd0;
    end
  end

  // Enables are registered from the next divider phase so they align with div.
  always_comb begin
    cpum2_en_d = 1'b0;
    cpu_en_d   = 1'b0;
    if (state_d == CPU_HOLD || state_d == RUN) begin
      cpum2_en_d = (div_d == 2'd1);
      cpu_en_d   = (div_d == 2'd2);
    end
  end

  always_comb begin
    loss_d = loss_q;
    if (!locked_s && state_q != WAIT_LOCK && loss_q != LOSS_CNT_MAX) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk_ppu or negedge rst_clocks_n) begin
    if (!rst_clocks_n) begin
      state_q    <= WAIT_LOCK;
      hold_q     <= '0;
      cpu_hold_q <= '0;
      db_cnt_q   <= '0;
      btn_db_q   <= 1'b0;
      div_q      <= 2'd0;
      rst_ppu_q  <= 1'b1;
      rst_cpu_q  <= 1'b1;
      cpu_en_q   <= 1'b0;
      cpum2_en_q <= 1'b0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cpu_hold_q <= cpu_hold_d;
      db_cnt_q   <= db_cnt_d;
      btn_db_q   <= btn_db_d;
      div_q      <= div_d;
      rst_ppu_q  <= rst_ppu_d;
      rst_cpu_q  <= rst_cpu_d;
      cpu_en_q   <= cpu_en_d;
      cpum2_en_q <= cpum2_en_d;
      loss_q     <= loss_d;
    end
  end

  assign rst_ppu       = rst_ppu_q;
  assign rst_cpu       = rst_cpu_q;
  assign cpu_en        = cpu_en_q;
  assign cpum2_en      = cpum2_en_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: vector table for the power-up sequence plus
// hand-written sequences for lock loss, button, saturation and async reset.
module tb_reset_seq;

  logic       clk_ppu = 1'b0;
  logic       rst_clocks_n;
  logic       locked;
  logic       btn_reset;
  logic       rst_ppu;
  logic       rst_cpu;
  logic       cpu_en;
  logic       cpum2_en;
  logic [1:0] seq_state;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  reset_seq #(
    .SYNC_STAGES     (2),
    .PPU_HOLD_CYCLES (64),
    .CPU_HOLD_CYCLES (8),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk_ppu       (clk_ppu),
    .rst_clocks_n  (rst_clocks_n),
    .locked        (locked),
    .btn_reset     (btn_reset),
    .rst_ppu       (rst_ppu),
    .rst_cpu       (rst_cpu),
    .cpu_en        (cpu_en),
    .cpum2_en      (cpum2_en),
    .seq_state     (seq_state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_ppu = ~clk_ppu;

  typedef struct {
    int         edge_n;
    logic [1:0] st;
    logic       ppu;
    logic       cpu;
    logic       en;
    logic       m2;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one active edge and sample 1 time unit later; also guard enable overlap.
  task automatic tick();
    @(posedge clk_ppu);
    #1;
    if (cpu_en && cpum2_en) begin
      errors++;
      $display("FAIL enable_overlap: cpu_en=1 cpum2_en=1 at %0t", $time);
    end
  endtask

  // which: 0 rst_ppu, 1 rst_cpu, 2 state==CPU_HOLD. Returns edges taken, -1 on timeout.
  task automatic wait_sig(input int which, input logic level, input int bound, output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      case (which)
        0:       v = rst_ppu;
        1:       v = rst_cpu;
        default: v = (seq_state == 2'd2);
      endcase
      if (v == level) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_block_reset();
    rst_clocks_n = 1'b0;
    #2;
    rst_clocks_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vi;
    int n;
    int bad;

    vecs[0]  = '{2,  2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3,  2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{66, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{67, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{68, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{69, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{70, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{72, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{89, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{90, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{91, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{92, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{93, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_clocks_n = 1'b0;
    locked       = 1'b0;
    btn_reset    = 1'b0;
    #12;
    check("reset_rst_ppu",   rst_ppu,       1);
    check("reset_rst_cpu",   rst_cpu,       1);
    check("reset_cpu_en",    cpu_en,        0);
    check("reset_cpum2_en",  cpum2_en,      0);
    check("reset_state",     seq_state,     0);
    check("reset_loss_cnt",  lock_loss_cnt, 0);

    // Power-up sequence: locked rises just after edge 0.
    tick();
    rst_clocks_n = 1'b1;
    tick();
    locked = 1'b1;
    vi = 0;
    for (int e = 1; e <= 95; e++) begin
      tick();
      if (vi < 13 && vecs[vi].edge_n == e) begin
        check($sformatf("seq_e%0d_state", e),    seq_state, vecs[vi].st);
        check($sformatf("seq_e%0d_rst_ppu", e),  rst_ppu,   vecs[vi].ppu);
        check($sformatf("seq_e%0d_rst_cpu", e),  rst_cpu,   vecs[vi].cpu);
        check($sformatf("seq_e%0d_cpu_en", e),   cpu_en,    vecs[vi].en);
        check($sformatf("seq_e%0d_cpum2_en", e), cpum2_en,  vecs[vi].m2);
        vi++;
      end
    end

    // Lock loss in RUN for 5 cycles, then full re-sequence.
    locked = 1'b0;
    wait_sig(0, 1'b1, 10, n);
    check("lockloss_run_latency", n, 3);
    check("lockloss_run_rst_cpu", rst_cpu, 1);
    check("lockloss_run_state", seq_state, 0);
    repeat (2) tick();
    check("lockloss_run_cnt", lock_loss_cnt, 1);
    locked = 1'b1;
    wait_sig(0, 1'b0, 200, n);
    check("relock_ppu_release", n, 67);
    wait_sig(1, 1'b0, 100, n);
    check("relock_cpu_release", n, 24);

    // Bouncing button never reaches the debounce threshold.
    bad = 0;
    for (int b = 0; b < 20; b++) begin
      btn_reset = 1'b1;
      repeat (5) begin tick(); if (rst_ppu || rst_cpu) bad++; end
      btn_reset = 1'b0;
      repeat (5) begin tick(); if (rst_ppu || rst_cpu) bad++; end
    end
    check("btn_bounce_no_reset", bad, 0);
    btn_reset = 1'b1;
    wait_sig(0, 1'b1, 40, n);
    check("btn_hold_latency", n, 19);
    check("btn_hold_state", seq_state, 0);
    check("btn_no_loss_count", lock_loss_cnt, 1);
    tick();
    btn_reset = 1'b0;
    wait_sig(0, 1'b0, 200, n);
    check("btn_release_ppu", n, 83);
    wait_sig(1, 1'b0, 100, n);
    check("btn_release_cpu", n, 24);

    // Lock loss during PPU_HOLD: rst_ppu must never drop.
    locked = 1'b0;
    pulse_block_reset();
    tick();
    check("blkrst_loss_clear", lock_loss_cnt, 0);
    locked = 1'b1;
    repeat (30) tick();
    check("ppuhold_e30_state", seq_state, 1);
    locked = 1'b0;
    bad = 0;
    repeat (40) begin tick(); if (!rst_ppu) bad++; end
    check("ppuhold_abort_no_release", bad, 0);
    check("ppuhold_abort_state", seq_state, 0);
    check("ppuhold_abort_cnt", lock_loss_cnt, 1);

    // Lock loss during CPU_HOLD: rst_ppu reasserts and enables stop.
    locked = 1'b1;
    wait_sig(2, 1'b1, 200, n);
    check("cpuhold_reached", n, 67);
    repeat (5) tick();
    locked = 1'b0;
    wait_sig(0, 1'b1, 10, n);
    check("cpuhold_abort_latency", n, 3);
    check("cpuhold_abort_enables", {cpu_en, cpum2_en}, 0);
    bad = 0;
    repeat (10) begin tick(); if (cpu_en || cpum2_en) bad++; end
    check("cpuhold_abort_en_quiet", bad, 0);
    check("cpuhold_abort_state", seq_state, 0);
    check("cpuhold_abort_cnt", lock_loss_cnt, 2);

    // Saturation of the lock-loss counter.
    pulse_block_reset();
    for (int e = 0; e < 300; e++) begin
      locked = 1'b1;
      repeat (4) tick();
      locked = 1'b0;
      repeat (4) tick();
      if (e == 253) check("loss_cnt_254", lock_loss_cnt, 254);
    end
    check("loss_cnt_saturated", lock_loss_cnt, 255);

    // Async block reset mid-RUN, between edges.
    locked = 1'b1;
    wait_sig(1, 1'b0, 200, n);
    check("run_before_async_rst", n, 91);
    repeat (4) tick();
    #2;
    rst_clocks_n = 1'b0;
    #1;
    check("async_rst_ppu",   rst_ppu,       1);
    check("async_rst_cpu",   rst_cpu,       1);
    check("async_cpu_en",    cpu_en,        0);
    check("async_cpum2_en",  cpum2_en,      0);
    check("async_state",     seq_state,     0);
    check("async_loss_cnt",  lock_loss_cnt, 0);
    #1;
    rst_clocks_n = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
